// File: rtl/freq_meas_sequencer.sv
// freq_meas_sequencer: runs period measurements and tracks frequency lock.
// Optional FREQ_MEAS_STATS_EN adds meas_cnt / to_cnt statistics outputs.
module freq_meas_sequencer #(
  parameter int LOCK_COUNT  = 4,
  parameter int MISS_COUNT  = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        done_tick,
  input  logic        is_5M,
  input  logic        is_10M,
  input  logic        is_20M,
  output logic        meas_start,
  output logic        busy,
  output logic        locked,
  output logic [1:0]  freq_code,
  output logic        lock_change,
  output logic        timeout_err
`ifdef FREQ_MEAS_STATS_EN
  ,
  output logic [15:0] meas_cnt,
  output logic [7:0]  to_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SAMPLE,
    S_EVAL,
    S_GAP
  } state_t;

  localparam logic [3:0]  LOCK_C  = 4'(LOCK_COUNT);
  localparam logic [3:0]  MISS_C  = 4'(MISS_COUNT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 2);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  state_t      state;
  logic [15:0] timer;
  logic [7:0]  gap_cnt;
  logic [3:0]  match_cnt;
  logic [3:0]  miss_cnt;
  logic [1:0]  cls;
  logic [1:0]  last_cls;

  logic [1:0]  samp_cls;
  logic [3:0]  match_nx;
  logic [3:0]  miss_nx;

`ifdef FREQ_MEAS_STATS_EN
  logic        to_flag;
`endif

  // Decode the classifier and precompute saturating counter updates
  always_comb begin
    samp_cls = 2'b00;
    match_nx = 4'd0;
    miss_nx  = miss_cnt;
    case ({is_5M, is_10M, is_20M})
      3'b100:  samp_cls = 2'b01;
      3'b010:  samp_cls = 2'b10;
      3'b001:  samp_cls = 2'b11;
      default: samp_cls = 2'b00;
    endcase
    if (cls == 2'b00)
      match_nx = 4'd0;
    else if (cls == last_cls)
      match_nx = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
    else
      match_nx = 4'd1;
    if (miss_cnt != 4'hF)
      miss_nx = miss_cnt + 4'd1;
  end

  // Measurement sequencer with registered outputs and lock tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      gap_cnt     <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      cls         <= '0;
      last_cls    <= '0;
      meas_start  <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      freq_code   <= 2'b00;
      lock_change <= 1'b0;
      timeout_err <= 1'b0;
`ifdef FREQ_MEAS_STATS_EN
      to_flag     <= 1'b0;
      meas_cnt    <= '0;
      to_cnt      <= '0;
`endif
    end else begin
      meas_start  <= 1'b0;
      lock_change <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state      <= S_START;
            meas_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          timer <= '0;
`ifdef FREQ_MEAS_STATS_EN
          to_flag <= 1'b0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 16'd1;
          if (done_tick) begin
            state <= S_SAMPLE;
          end else if (timer == TO_LAST) begin
            cls         <= 2'b00;
            timeout_err <= 1'b1;
`ifdef FREQ_MEAS_STATS_EN
            to_flag     <= 1'b1;
`endif
            state       <= S_EVAL;
          end
        end
        S_SAMPLE: begin
          cls   <= samp_cls;
          state <= S_EVAL;
        end
        S_EVAL: begin
          match_cnt <= match_nx;
          last_cls  <= cls;
          if (!locked) begin
            if (match_nx >= LOCK_C) begin
              locked      <= 1'b1;
              freq_code   <= cls;
              lock_change <= 1'b1;
            end
          end else if (cls == freq_code) begin
            miss_cnt <= 4'd0;
          end else if (miss_nx >= MISS_C) begin
            locked      <= 1'b0;
            freq_code   <= 2'b00;
            miss_cnt    <= 4'd0;
            lock_change <= 1'b1;
          end else begin
            miss_cnt <= miss_nx;
          end
`ifdef FREQ_MEAS_STATS_EN
          if (meas_cnt != 16'hFFFF)
            meas_cnt <= meas_cnt + 16'd1;
          if (to_flag && to_cnt != 8'hFF)
            to_cnt <= to_cnt + 8'd1;
`endif
          gap_cnt <= '0;
          if (GAP_CYC == 0) begin
            state      <= enable ? S_START : S_IDLE;
            meas_start <= enable;
            busy       <= enable;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= enable ? S_START : S_IDLE;
            meas_start <= enable;
            busy       <= enable;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
